// File: rtl/loop_ctrl_from_t_sub_1.sv
`default_nettype none
// ============================================================================
// Module   : loop_ctrl_from_t_sub_1
// Brief    : Nested down-counting (i, j) loop sequencer, t_sub_1..0 on both
//            indices, ce-gated. Optional abort input under LOOP_CTRL_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module loop_ctrl_from_t_sub_1 #(
  parameter  int DATA_WIDTH = 8,
  localparam int CW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          start,
  input  logic          step,
`ifdef LOOP_CTRL_ABORT_EN
  input  logic          abort,
`endif
  input  logic [CW-1:0] t_sub_1,
  output logic          busy,
  output logic          o_valid,
  output logic [CW-1:0] o_i,
  output logic [CW-1:0] o_j,
  output logic          o_last_j,
  output logic          o_last_i,
  output logic          done
);

  localparam logic [CW-1:0] c_one  = CW'(1);
  localparam logic [CW-1:0] c_zero = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_t;
  logic [CW-1:0] r_i;
  logic [CW-1:0] r_j;
  logic          w_abort;

`ifdef LOOP_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_t     <= c_zero;
      r_i     <= c_zero;
      r_j     <= c_zero;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_t     <= t_sub_1;
            r_i     <= t_sub_1;
            r_j     <= t_sub_1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_i     <= c_zero;
            r_j     <= c_zero;
          end else if (step) begin
            // Inner index wraps back to the latched bound, never below zero
            if (r_j != c_zero) begin
              r_j <= r_j - c_one;
            end else if (r_i != c_zero) begin
              r_j <= r_t;
              r_i <= r_i - c_one;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // start is deliberately not looked at on this edge
          r_state <= S_IDLE;
          if (w_abort) begin
            r_i <= c_zero;
            r_j <= c_zero;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are plain decodes of the state flops
  assign busy     = (r_state != S_IDLE);
  assign o_valid  = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign o_i      = r_i;
  assign o_j      = r_j;
  assign o_last_j = o_valid & (r_j == c_zero);
  assign o_last_i = o_valid & (r_i == c_zero);

endmodule
`default_nettype wire

// File: tb/tb_loop_ctrl_from_t_sub_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_loop_ctrl_from_t_sub_1
// Brief    : Scoreboard bench for loop_ctrl_from_t_sub_1 (abort scenario is
//            exercised when LOOP_CTRL_ABORT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_loop_ctrl_from_t_sub_1;

  localparam int CW = 3;

  typedef struct packed {
    logic [CW-1:0] i;
    logic [CW-1:0] j;
    logic          li;
    logic          lj;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce = 1'b0;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic [CW-1:0] t_sub_1 = '0;
  logic          busy, o_valid, o_last_j, o_last_i, done;
  logic [CW-1:0] o_i, o_j;
`ifdef LOOP_CTRL_ABORT_EN
  logic          abort = 1'b0;
`endif

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  loop_ctrl_from_t_sub_1 #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .start    (start),
    .step     (step),
`ifdef LOOP_CTRL_ABORT_EN
    .abort    (abort),
`endif
    .t_sub_1  (t_sub_1),
    .busy     (busy),
    .o_valid  (o_valid),
    .o_i      (o_i),
    .o_j      (o_j),
    .o_last_j (o_last_j),
    .o_last_i (o_last_i),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps the loop until (pi, pj) is presented; leaves step=0 on exit.
  task automatic wait_pair(input logic [CW-1:0] pi, input logic [CW-1:0] pj, input string name);
    int n = 0;
    ce = 1'b1;
    while (!(o_valid === 1'b1 && o_i == pi && o_j == pj) && n < 100) begin
      step = 1'b1;
      tick();
      n++;
    end
    step = 1'b0;
    tests++;
    if (n >= 100) begin
      fails++;
      $display("FAIL %s wait_pair: timed out, at (%0d,%0d) want (%0d,%0d)", name, o_i, o_j, pi, pj);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    ce = 1'b1;
    start = 1'b0;
    step = 1'b1;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    step = 1'b0;
    tests++;
    if (n >= 100) begin
      fails++;
      $display("FAIL %s drain: busy stuck, got %b want 0", name, busy);
    end
  endtask

  task automatic run_pass(input logic [CW-1:0] t, input bit stall, input bit chg_t, input string name);
    exp_t          e;
    int            steps = 0, dones = 0, lasti = 0, lastj = 0;
    int            ce_off = 0, step_off = 0, cyc;
    bit            exp_done = 1'b0, frz;
    logic [CW-1:0] pi, pj;

    sb.delete();
    for (int a = int'(t); a >= 0; a--) begin
      for (int b = int'(t); b >= 0; b--) begin
        e.i  = CW'(a);
        e.j  = CW'(b);
        e.li = (a == 0);
        e.lj = (b == 0);
        sb.push_back(e);
      end
    end

    ce = 1'b1; step = 1'b0; t_sub_1 = t; start = 1'b1;
    tick();
    start = 1'b0;
    if (chg_t) t_sub_1 = 3'd7;
    tests++;
    if (o_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s valid_latency: got %b want 1", name, o_valid);
    end

    for (cyc = 0; cyc < 300; cyc++) begin
      if (exp_done) begin
        exp_done = 1'b0;
        tests++;
        if (done !== 1'b1) begin
          fails++;
          $display("FAIL %s done_after_last: got %b want 1", name, done);
        end
      end
      if (done === 1'b1) dones++;
      if (dones > 0 && busy === 1'b0) break;

      ce = 1'b1; step = 1'b1;
      if (stall && steps == 7 && ce_off < 3) begin
        ce = 1'b0; ce_off++;
      end else if (stall && o_valid === 1'b1 && o_i == 3'd2 && o_j == 3'd0 && step_off < 2) begin
        step = 1'b0; step_off++;
      end

      if (ce && step && o_valid === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL %s extra_step: got (%0d,%0d) want none", name, o_i, o_j);
        end else begin
          e = sb.pop_front();
          if ({o_i, o_j, o_last_i, o_last_j} !== {e.i, e.j, e.li, e.lj}) begin
            fails++;
            $display("FAIL %s pair: got (%0d,%0d) li=%b lj=%b want (%0d,%0d) li=%b lj=%b",
                     name, o_i, o_j, o_last_i, o_last_j, e.i, e.j, e.li, e.lj);
          end
          steps++;
          if (o_last_i === 1'b1) lasti++;
          if (o_last_j === 1'b1) lastj++;
          if (sb.size() == 0) exp_done = 1'b1;
        end
      end

      frz = !(ce && step) && (o_valid === 1'b1);
      pi = o_i; pj = o_j;
      tick();
      if (frz) begin
        tests++;
        if (o_i !== pi || o_j !== pj || o_valid !== 1'b1) begin
          fails++;
          $display("FAIL %s hold: got (%0d,%0d) v=%b want (%0d,%0d) v=1", name, o_i, o_j, o_valid, pi, pj);
        end
      end
    end
    ce = 1'b1; step = 1'b0;

    tests++;
    if (cyc >= 300) begin
      fails++;
      $display("FAIL %s timeout: got %0d cycles want <300", name, cyc);
    end
    tests++;
    if (steps != (int'(t) + 1) * (int'(t) + 1)) begin
      fails++;
      $display("FAIL %s step_count: got %0d want %0d", name, steps, (int'(t) + 1) * (int'(t) + 1));
    end
    tests++;
    if (dones != 1) begin
      fails++;
      $display("FAIL %s done_cycles: got %0d want 1", name, dones);
    end
    tests++;
    if (lasti != int'(t) + 1 || lastj != int'(t) + 1) begin
      fails++;
      $display("FAIL %s last_counts: got li=%0d lj=%0d want %0d", name, lasti, lastj, int'(t) + 1);
    end
    tests++;
    if ({busy, o_valid, done} !== 3'b000) begin
      fails++;
      $display("FAIL %s end_idle: got b/v/d=%b%b%b want 000", name, busy, o_valid, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; start = 1'b0; step = 1'b0;
    tick();
    rst = 1'b0;
    tests++;
    if ({busy, o_valid, done, o_last_i, o_last_j, o_i, o_j} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got b=%b v=%b d=%b i=%0d j=%0d want all 0", busy, o_valid, done, o_i, o_j);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++;
      if (busy !== 1'b0 || o_valid !== 1'b0) begin
        fails++;
        $display("FAIL idle_hold: got b=%b v=%b want 0 0", busy, o_valid);
      end
    end
    ce = 1'b0; start = 1'b1; t_sub_1 = 3'd2;
    tick();
    start = 1'b0; ce = 1'b1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ce_low_start: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    ce = 1'b1; t_sub_1 = 3'd0; start = 1'b1; step = 1'b0;
    tick();
    start = 1'b0;
    tests++;
    if ({o_valid, o_i, o_j, o_last_i, o_last_j} !== {1'b1, 3'd0, 3'd0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL min_pair: got v=%b (%0d,%0d) li=%b lj=%b want 1 (0,0) 1 1", o_valid, o_i, o_j, o_last_i, o_last_j);
    end
    step = 1'b1;
    tick();
    step = 1'b0; start = 1'b1;
    tests++;
    if (done !== 1'b1 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL min_done: got d=%b v=%b want 1 0", done, o_valid);
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL done_ignores_start: got busy=%b want 0", busy);
    end
    tick();
    start = 1'b0;
    tests++;
    if (o_valid !== 1'b1) begin
      fails++;
      $display("FAIL restart_after_done: got v=%b want 1", o_valid);
    end
    drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    ce = 1'b1; t_sub_1 = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_pair(3'd2, 3'd1, "reset_mid");
    rst = 1'b1; step = 1'b1;
    tick();
    rst = 1'b0; step = 1'b0;
    tests++;
    if ({busy, o_valid, done, o_last_i, o_last_j, o_i, o_j} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got b=%b v=%b d=%b i=%0d j=%0d want all 0", busy, o_valid, done, o_i, o_j);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_no_done: got d=%b b=%b want 0 0", done, busy);
      end
    end
    run_pass(3'd1, 1'b0, 1'b0, "after_reset");
  endtask

`ifdef LOOP_CTRL_ABORT_EN
  task automatic test_abort();
    ce = 1'b1; t_sub_1 = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_pair(3'd3, 3'd2, "abort");
    abort = 1'b1; step = 1'b1;
    tick();
    abort = 1'b0; step = 1'b0;
    tests++;
    if ({busy, o_valid, done, o_i, o_j} !== '0) begin
      fails++;
      $display("FAIL abort_idle: got b=%b v=%b d=%b i=%0d j=%0d want all 0", busy, o_valid, done, o_i, o_j);
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_done: got d=%b want 0", done);
    end
    abort = 1'b1; start = 1'b1; t_sub_1 = 3'd2;
    tick();
    abort = 1'b0; start = 1'b0;
    tests++;
    if (o_valid !== 1'b1 || o_i !== 3'd2 || o_j !== 3'd2) begin
      fails++;
      $display("FAIL abort_with_start: got v=%b (%0d,%0d) want 1 (2,2)", o_valid, o_i, o_j);
    end
    drain("abort");
  endtask
`endif

  initial begin
    test_reset();
    run_pass(3'd4, 1'b0, 1'b0, "full_pass");
    run_pass(3'd4, 1'b1, 1'b0, "stall_pass");
    run_pass(3'd0, 1'b0, 1'b0, "min_bound");
    run_pass(3'd2, 1'b0, 1'b1, "bound_change");
    test_back_to_back();
    test_reset_mid();
`ifdef LOOP_CTRL_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
